// File: rtl/aes_queue_wrapper.sv
// Queued AES-128 front end: input FIFO -> single iterative AES_top core -> output FIFO.
// Optional CTR mode via AES_QUEUE_CTR_EN (adds nonce/ctr_load ports); default build is ECB.

// Iterative AES-128 encryptor with a fixed key; one round per clock, statue pulses with the result.
module AES_top #(
    parameter logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plain_text_in,
    output logic [127:0] cyphertext_out,
    output logic         statue
);
    logic [127:0] st, rk, st_nxt, rk_nxt;
    logic [7:0]   rcon;
    logic [3:0]   round;
    logic         run;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
        r = gmul(r, r);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i sits at row i%4, column i/4; byte 0 is the most significant
    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c+1];
            a2 = t[4*c+2];
            a3 = t[4*c+3];
            if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
            else o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o ^ k;
    endfunction

    always_comb begin
        rk_nxt = next_key(rk, rcon);
        st_nxt = round_fn(st, rk_nxt, round == 4'd10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= '0;
            rk             <= '0;
            rcon           <= 8'h01;
            round          <= '0;
            run            <= 1'b0;
            cyphertext_out <= '0;
            statue         <= 1'b0;
        end else begin
            statue <= 1'b0;
            if (start) begin
                st    <= plain_text_in ^ KEY;
                rk    <= KEY;
                rcon  <= 8'h01;
                round <= 4'd1;
                run   <= 1'b1;
            end else if (run) begin
                st    <= st_nxt;
                rk    <= rk_nxt;
                rcon  <= xtime(rcon);
                round <= round + 4'd1;
                if (round == 4'd10) begin
                    run            <= 1'b0;
                    cyphertext_out <= st_nxt;
                    statue         <= 1'b1;
                end
            end
        end
    end
endmodule

module aes_queue_wrapper #(
    parameter int unsigned IN_DEPTH  = 4,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [127:0]                 in_data,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [127:0]                 out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(IN_DEPTH):0]    in_level,
    output logic [$clog2(OUT_DEPTH):0]   out_level,
    output logic                         busy
`ifdef AES_QUEUE_CTR_EN
    ,
    input  logic [95:0]                  nonce,
    input  logic                         ctr_load
`endif
);
    localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
    localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
    localparam int unsigned IN_LW  = IN_AW + 1;
    localparam int unsigned OUT_LW = OUT_AW + 1;
    localparam int unsigned ENT_W  = TAG_W + 128;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    state_t             state, state_nxt;
    logic               core_start, core_done;
    logic [127:0]       core_pt, core_ct;
    logic               in_push, in_pop, out_push, out_pop, rsv;
    logic [IN_AW-1:0]   in_wr, in_rd;
    logic [OUT_AW-1:0]  out_wr, out_rd;
    logic [ENT_W-1:0]   in_mem  [IN_DEPTH];
    logic [ENT_W-1:0]   out_mem [OUT_DEPTH];
    logic [ENT_W-1:0]   in_head, out_head, out_ent;
    logic [TAG_W-1:0]   hold_tag;

    assign in_head   = in_mem[in_rd];
    assign out_head  = out_mem[out_rd];
    assign in_ready  = in_level != IN_LW'(IN_DEPTH);
    assign out_valid = out_level != '0;
    assign in_push   = in_valid && in_ready;
    assign out_pop   = out_valid && out_ready;
    assign out_data  = out_valid ? out_head[127:0] : '0;
    assign out_tag   = out_valid ? out_head[ENT_W-1:128] : '0;
    assign rsv       = state != IDLE;
    assign busy      = rsv || (in_level != '0) || (out_level != '0);

`ifdef AES_QUEUE_CTR_EN
    logic [31:0]  ctr;
    logic [127:0] hold_data;

    // Counter advances once per issued block; load wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr       <= '0;
            hold_data <= '0;
        end else begin
            if (ctr_load) ctr <= '0;
            else if (in_pop) ctr <= ctr + 32'd1;
            if (in_pop) hold_data <= in_head[127:0];
        end
    end

    assign core_pt = {nonce, ctr};
    assign out_ent = {hold_tag, core_ct ^ hold_data};
`else
    assign core_pt = in_head[127:0];
    assign out_ent = {hold_tag, core_ct};
`endif

    // Input FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_wr    <= '0;
            in_rd    <= '0;
            in_level <= '0;
        end else begin
            if (in_push) in_wr <= in_wr + IN_AW'(1);
            if (in_pop) in_rd <= in_rd + IN_AW'(1);
            in_level <= in_level + IN_LW'(in_push) - IN_LW'(in_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wr] <= {in_tag, in_data};
    end

    // Output FIFO; a slot is reserved at issue so the core push can never overflow it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr    <= '0;
            out_rd    <= '0;
            out_level <= '0;
        end else begin
            if (out_push) out_wr <= out_wr + OUT_AW'(1);
            if (out_pop) out_rd <= out_rd + OUT_AW'(1);
            out_level <= out_level + OUT_LW'(out_push) - OUT_LW'(out_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wr] <= out_ent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_tag <= '0;
        end else begin
            state <= state_nxt;
            if (in_pop) hold_tag <= in_head[ENT_W-1:128];
        end
    end

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        in_pop     = 1'b0;
        out_push   = 1'b0;
        case (state)
            IDLE: begin
                if ((in_level != '0) &&
                    ((out_level + OUT_LW'(rsv)) < OUT_LW'(OUT_DEPTH)))
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                core_start = 1'b1;
                in_pop     = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    out_push  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    AES_top u_core (
        .clk            (clk),
        .rst            (!rst_n),
        .start          (core_start),
        .plain_text_in  (core_pt),
        .cyphertext_out (core_ct),
        .statue         (core_done)
    );
endmodule
